// File: rtl/ising_weight_axi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ising_weight_axi_ctrl
// Brief   : AXI4-Lite slave for the per-cell weight registers of the N x N
//           oscillator array, plus the array-wide oscillator reset control.
// Rev     : 1.0
// ============================================================================
module ising_weight_axi_ctrl #(
    parameter int N           = 8,
    parameter int NUM_WEIGHTS = 15,
    parameter int ADDR_W      = 16
) (
    input  logic                  clk,
    input  logic                  axi_rstn,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  cell_wready,
    output logic [N*N-1:0]        cell_match,
    output logic [31:0]           cell_wdata,
    input  logic [N*N*32-1:0]     cell_rdata,
    output logic                  ising_rstn
);

    localparam int c_NCELLS = N * N;
    localparam int c_CELL_W = (c_NCELLS > 1) ? $clog2(c_NCELLS) : 1;
    localparam int c_IDX_W  = ADDR_W - 2;
    localparam logic [c_IDX_W-1:0] c_CTRL_IDX = c_IDX_W'(c_NCELLS);
    localparam logic [31:0]        c_WLIMIT   = 32'(NUM_WEIGHTS);
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WSTB  = 3'd1;
    localparam logic [2:0] c_WRESP = 3'd2;
    localparam logic [2:0] c_RCAP  = 3'd3;
    localparam logic [2:0] c_RRESP = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_ready_en;
    logic               r_aw_full;
    logic               r_w_full;
    logic               r_ar_full;
    logic [c_IDX_W-1:0] r_aw_idx;
    logic [c_IDX_W-1:0] r_ar_idx;
    logic [31:0]        r_wdata;
    logic               r_prio_wr;
    logic               r_ising_rstn;
    logic [31:0]        r_cell_wdata;
    logic [1:0]         r_bresp;
    logic [1:0]         r_rresp;
    logic [31:0]        r_rdata;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_wr_grant;
    logic               w_rd_grant;
    logic               w_aw_is_cell;
    logic               w_aw_is_ctrl;
    logic               w_cell_wr;
    logic               w_wr_legal;
    logic               w_ar_is_cell;
    logic               w_ar_is_ctrl;
    logic [c_CELL_W-1:0] w_aw_cell;
    logic [c_CELL_W-1:0] w_ar_cell;
    logic [31:0]        w_cell_rd;
    logic               w_unused;

    // Byte-lane bits of the addresses carry no information (word-only map).
    assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign w_aw_hs = s_awvalid & s_awready;
    assign w_w_hs  = s_wvalid  & s_wready;
    assign w_ar_hs = s_arvalid & s_arready;

    // Arbitration also sees handshakes completing this edge, so a write pair
    // or read reaches WSTB/RCAP in the very next cycle.
    always_comb begin
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (r_state == c_IDLE) begin
            if ((r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) &
                (r_prio_wr | ~(r_ar_full | w_ar_hs)))
                w_wr_grant = 1'b1;
            else if (r_ar_full | w_ar_hs)
                w_rd_grant = 1'b1;
        end
    end

    assign w_aw_cell    = r_aw_idx[c_CELL_W-1:0];
    assign w_aw_is_cell = (r_aw_idx < c_CTRL_IDX);
    assign w_aw_is_ctrl = (r_aw_idx == c_CTRL_IDX);
    assign w_cell_wr    = w_aw_is_cell & (r_wdata < c_WLIMIT);
    assign w_wr_legal   = w_cell_wr | w_aw_is_ctrl;

    assign w_ar_cell    = r_ar_idx[c_CELL_W-1:0];
    assign w_ar_is_cell = (r_ar_idx < c_CTRL_IDX);
    assign w_ar_is_ctrl = (r_ar_idx == c_CTRL_IDX);
    assign w_cell_rd    = cell_rdata[{w_ar_cell, 5'b0} +: 32];

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_wr_grant)
                    w_next = c_WSTB;
                else if (w_rd_grant)
                    w_next = c_RCAP;
            end
            c_WSTB:  w_next = c_WRESP;
            c_WRESP: if (s_bready) w_next = c_IDLE;
            c_RCAP:  w_next = c_RRESP;
            c_RRESP: if (s_rready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        s_awready   = r_ready_en & (r_state == c_IDLE) & ~r_aw_full;
        s_wready    = r_ready_en & (r_state == c_IDLE) & ~r_w_full;
        s_arready   = r_ready_en & ~r_ar_full;
        s_bvalid    = (r_state == c_WRESP);
        s_rvalid    = (r_state == c_RRESP);
        cell_wready = (r_state == c_WSTB) & w_cell_wr;
        cell_match  = '0;
        if (cell_wready)
            cell_match[w_aw_cell] = 1'b1;
        // Present fresh data during the strobe, then hold the last legal value.
        cell_wdata  = cell_wready ? r_wdata : r_cell_wdata;
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_ready_en   <= 1'b0;
            r_aw_full    <= 1'b0;
            r_w_full     <= 1'b0;
            r_ar_full    <= 1'b0;
            r_aw_idx     <= '0;
            r_ar_idx     <= '0;
            r_wdata      <= '0;
            r_prio_wr    <= 1'b1;
            r_ising_rstn <= 1'b0;
            r_cell_wdata <= '0;
            r_bresp      <= c_OKAY;
            r_rresp      <= c_OKAY;
            r_rdata      <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s_awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_wdata;
            end
            if (w_ar_hs) begin
                r_ar_full <= 1'b1;
                r_ar_idx  <= s_araddr[ADDR_W-1:2];
            end
            if (w_wr_grant | w_rd_grant)
                r_prio_wr <= ~r_prio_wr;
            if (r_state == c_WSTB) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bresp   <= w_wr_legal ? c_OKAY : c_SLVERR;
                if (w_aw_is_ctrl)
                    r_ising_rstn <= r_wdata[0];
                if (w_cell_wr)
                    r_cell_wdata <= r_wdata;
            end
            if (r_state == c_RCAP) begin
                r_ar_full <= 1'b0;
                if (w_ar_is_cell) begin
                    r_rdata <= w_cell_rd;
                    r_rresp <= c_OKAY;
                end else if (w_ar_is_ctrl) begin
                    r_rdata <= {31'b0, r_ising_rstn};
                    r_rresp <= c_OKAY;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= c_SLVERR;
                end
            end
        end
    end

    assign s_bresp    = r_bresp;
    assign s_rresp    = r_rresp;
    assign s_rdata    = r_rdata;
    assign ising_rstn = r_ising_rstn;

endmodule
`default_nettype wire

// File: tb/tb_ising_weight_axi_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ising_weight_axi_ctrl
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a behavioural register-map model.
// Rev     : 1.0
// ============================================================================
module tb_ising_weight_axi_ctrl;

    localparam int N      = 8;
    localparam int NCELL  = N * N;
    localparam int NV     = 17;

    logic                 clk = 1'b0;
    logic                 axi_rstn;
    logic [15:0]          s_awaddr;
    logic                 s_awvalid;
    logic                 s_awready;
    logic [31:0]          s_wdata;
    logic                 s_wvalid;
    logic                 s_wready;
    logic [1:0]           s_bresp;
    logic                 s_bvalid;
    logic                 s_bready;
    logic [15:0]          s_araddr;
    logic                 s_arvalid;
    logic                 s_arready;
    logic [31:0]          s_rdata;
    logic [1:0]           s_rresp;
    logic                 s_rvalid;
    logic                 s_rready;
    logic                 cell_wready;
    logic [NCELL-1:0]     cell_match;
    logic [31:0]          cell_wdata;
    logic [NCELL*32-1:0]  cell_rdata;
    logic                 ising_rstn;

    ising_weight_axi_ctrl #(.N(N), .NUM_WEIGHTS(15), .ADDR_W(16)) dut (
        .clk(clk), .axi_rstn(axi_rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .cell_wready(cell_wready), .cell_match(cell_match), .cell_wdata(cell_wdata),
        .cell_rdata(cell_rdata), .ising_rstn(ising_rstn)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_strobe = 0;
    int last_strobe_cyc = -1;
    logic [NCELL-1:0] last_match = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the oscillator array: each cell latches on its strobe.
    logic [31:0] cell_mem [NCELL] = '{default: '0};
    always @(posedge clk) begin
        if (cell_wready)
            for (int k = 0; k < NCELL; k++)
                if (cell_match[k]) cell_mem[k] <= cell_wdata;
    end
    always_comb begin
        cell_rdata = '0;
        for (int k = 0; k < NCELL; k++) cell_rdata[32*k +: 32] = cell_mem[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    always @(negedge clk) begin
        if (cell_wready) begin
            n_strobe++;
            last_strobe_cyc = cyc;
            last_match = cell_match;
            check("strobe_onehot", 64'($onehot(cell_match)), 64'd1);
        end else if (cell_match != '0) begin
            check("match_without_strobe", cell_match, 64'd0);
        end
    end

    // Register-map reference model.
    logic [31:0] m_w [NCELL] = '{default: '0};
    logic        m_ctrl = 1'b0;

    function automatic void model_write(input logic [15:0] addr, input logic [31:0] d,
                                        output logic [1:0] resp, output int strobes);
        int idx;
        idx = int'(addr) / 4;
        resp = 2'b10;
        strobes = 0;
        if (idx < NCELL) begin
            if (d < 32'd15) begin
                m_w[idx] = d;
                resp = 2'b00;
                strobes = 1;
            end
        end else if (idx == NCELL) begin
            m_ctrl = d[0];
            resp = 2'b00;
        end
    endfunction

    function automatic void model_read(input logic [15:0] addr, output logic [31:0] d,
                                       output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        d = '0;
        resp = 2'b10;
        if (idx < NCELL) begin
            d = m_w[idx];
            resp = 2'b00;
        end else if (idx == NCELL) begin
            d = {31'b0, m_ctrl};
            resp = 2'b00;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        axi_rstn = 1'b0;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        m_ctrl = 1'b0;
        repeat (2) tick();
        axi_rstn = 1'b1;
        tick();
    endtask

    // w_lead > 0: W offered that many cycles before AW; < 0: AW first.
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input int w_lead,
                            input int bdelay, output logic [1:0] resp, output int strobes,
                            output int hs_cyc, output int bv_cyc);
        int aw_at, w_at, c, s0;
        bit aw_pend, w_pend, aw_hs, w_hs, done;
        s0 = n_strobe;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        aw_pend = 1; w_pend = 1; c = 0; hs_cyc = -1; bv_cyc = -1; resp = 2'b11; done = 0;
        s_awaddr = addr;
        s_wdata = data;
        while ((aw_pend || w_pend) && c < 50) begin
            s_awvalid = aw_pend && (c >= aw_at);
            s_wvalid  = w_pend && (c >= w_at);
            @(negedge clk);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick();
            if (aw_hs) aw_pend = 0;
            if (w_hs) w_pend = 0;
            c++;
        end
        s_awvalid = 0;
        s_wvalid = 0;
        hs_cyc = cyc;
        if (aw_pend || w_pend) timeout_fail("write_addr_data");
        c = 0;
        while (!done && c < 40) begin
            s_bready = (c >= bdelay);
            @(negedge clk);
            if (s_bvalid && bv_cyc < 0) bv_cyc = cyc;
            if (s_bvalid && s_bready) begin
                resp = s_bresp;
                done = 1;
            end
            tick();
            c++;
        end
        s_bready = 0;
        if (!done) timeout_fail("write_resp");
        strobes = n_strobe - s0;
    endtask

    task automatic do_read(input logic [15:0] addr, input int rdelay, output logic [31:0] data,
                           output logic [1:0] resp, output int ar_cyc, output int rv_cyc);
        int c;
        bit hs, done;
        c = 0; hs = 0; done = 0; ar_cyc = -1; rv_cyc = -1; data = '1; resp = 2'b11;
        s_araddr = addr;
        while (!hs && c < 50) begin
            s_arvalid = 1;
            @(negedge clk);
            hs = s_arready;
            tick();
            c++;
        end
        s_arvalid = 0;
        ar_cyc = cyc;
        if (!hs) timeout_fail("read_addr");
        c = 0;
        while (!done && c < 40) begin
            s_rready = (c >= rdelay);
            @(negedge clk);
            if (s_rvalid && rv_cyc < 0) rv_cyc = cyc;
            if (s_rvalid && s_rready) begin
                data = s_rdata;
                resp = s_rresp;
                done = 1;
            end
            tick();
            c++;
        end
        s_rready = 0;
        if (!done) timeout_fail("read_resp");
    endtask

    typedef struct {
        bit          is_rd;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          w_lead;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_strobes;
        logic        exp_irst;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        logic [1:0]  resp, mresp;
        logic [31:0] rd, md;
        int str, mstr, hs, bv, arc, rv, bad, c, s0, sel, idx, lead;
        logic [15:0] addr;
        logic [31:0] data;

        vecs[0]  = '{0, 16'h0014, 32'd3,          0, 2'b00, 32'd0,  1, 1'b0};
        vecs[1]  = '{1, 16'h0014, 32'd0,          0, 2'b00, 32'd3,  0, 1'b0};
        vecs[2]  = '{0, 16'h0000, 32'd14,         3, 2'b00, 32'd0,  1, 1'b0};
        vecs[3]  = '{0, 16'h0000, 32'd15,         0, 2'b10, 32'd0,  0, 1'b0};
        vecs[4]  = '{1, 16'h0000, 32'd0,          0, 2'b00, 32'd14, 0, 1'b0};
        vecs[5]  = '{0, 16'h0100, 32'd1,         -1, 2'b00, 32'd0,  0, 1'b1};
        vecs[6]  = '{1, 16'h0100, 32'd0,          0, 2'b00, 32'd1,  0, 1'b1};
        vecs[7]  = '{0, 16'h0100, 32'd0,          2, 2'b00, 32'd0,  0, 1'b0};
        vecs[8]  = '{1, 16'h0100, 32'd0,          0, 2'b00, 32'd0,  0, 1'b0};
        vecs[9]  = '{0, 16'h0104, 32'd5,          0, 2'b10, 32'd0,  0, 1'b0};
        vecs[10] = '{1, 16'h0104, 32'd0,          0, 2'b10, 32'd0,  0, 1'b0};
        vecs[11] = '{0, 16'h00FC, 32'd7,         -2, 2'b00, 32'd0,  1, 1'b0};
        vecs[12] = '{1, 16'h00FF, 32'd0,          0, 2'b00, 32'd7,  0, 1'b0};
        vecs[13] = '{0, 16'h001C, 32'd0,          1, 2'b00, 32'd0,  1, 1'b0};
        vecs[14] = '{1, 16'h001C, 32'd0,          0, 2'b00, 32'd0,  0, 1'b0};
        vecs[15] = '{0, 16'h0020, 32'h8000_0003,  0, 2'b10, 32'd0,  0, 1'b0};
        vecs[16] = '{1, 16'h0020, 32'd0,          0, 2'b00, 32'd0,  0, 1'b0};

        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;

        // Reset values and first-cycle readiness.
        axi_rstn = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_flags", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cell_wready, ising_rstn}, 0);
        check("rst_match", cell_match, 0);
        check("rst_wdata", cell_wdata, 0);
        check("rst_resp_data", {s_bresp, s_rresp, s_rdata}, 0);
        @(posedge clk); #1;
        axi_rstn = 1'b1;
        tick();
        check("rst_ready_next", {s_awready, s_wready, s_arready}, 3'b111);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            if (!vecs[i].is_rd) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].w_lead, 0, resp, str, hs, bv);
                model_write(vecs[i].addr, vecs[i].wdata, mresp, mstr);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("v%0d_strobes", i), str, vecs[i].exp_strobes);
                check($sformatf("v%0d_bvalid_lat", i), bv - hs, 1);
                if (vecs[i].exp_strobes == 1) begin
                    check($sformatf("v%0d_strobe_cyc", i), last_strobe_cyc, hs);
                    check($sformatf("v%0d_match", i), last_match, 64'd1 << (vecs[i].addr >> 2));
                end
            end else begin
                do_read(vecs[i].addr, 0, rd, resp, arc, rv);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("v%0d_rvalid_lat", i), rv - arc, 1);
            end
            check($sformatf("v%0d_ising_rstn", i), ising_rstn, vecs[i].exp_irst);
        end

        // Write pair and read arriving together, both responses back-pressured.
        apply_reset();
        s_awaddr = 16'h0008; s_wdata = 32'd9; s_araddr = 16'h0008;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        @(negedge clk);
        check("simul_ready", {s_awready, s_wready, s_arready}, 3'b111);
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        model_write(16'h0008, 32'd9, mresp, mstr);
        @(negedge clk);
        check("simul_strobe", {cell_wready, cell_match}, {1'b1, 64'd1 << 2});
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (!(s_bvalid && s_bresp == 2'b00 && !s_rvalid)) bad++;
        end
        check("simul_bhold", bad, 0);
        s_bready = 1;
        tick();
        s_bready = 0;
        c = 0;
        while (!s_rvalid && c < 20) begin tick(); c++; end
        check("simul_rvalid", s_rvalid, 1);
        model_read(16'h0008, md, mresp);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!(s_rvalid && s_rdata == md && s_rresp == mresp && !s_bvalid)) bad++;
            tick();
        end
        check("simul_rhold", bad, 0);
        s_rready = 1;
        tick();
        s_rready = 0;
        @(negedge clk);
        check("simul_rdone", s_rvalid, 0);
        tick();

        // Reset pulse while a write response is outstanding.
        do_write(16'h0100, 32'd1, 0, 0, resp, str, hs, bv);
        model_write(16'h0100, 32'd1, mresp, mstr);
        check("pre_rst_ctrl", ising_rstn, m_ctrl);
        s_awaddr = 16'h000C; s_wdata = 32'd4; s_awvalid = 1; s_wvalid = 1;
        @(negedge clk);
        check("pre_rst_ready", {s_awready, s_wready}, 2'b11);
        tick();
        s_awvalid = 0; s_wvalid = 0;
        model_write(16'h000C, 32'd4, mresp, mstr);
        c = 0;
        while (!s_bvalid && c < 10) begin tick(); c++; end
        check("pre_rst_bvalid", s_bvalid, 1);
        s0 = n_strobe;
        axi_rstn = 1'b0;
        m_ctrl = 1'b0;
        #1;
        check("rst_bvalid_drop", s_bvalid, 0);
        check("rst_ctrl_drop", ising_rstn, m_ctrl);
        tick();
        axi_rstn = 1'b1;
        repeat (5) tick();
        check("rst_no_strobe", n_strobe, s0);
        check("rst_no_bvalid", s_bvalid, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) idx = int'($urandom_range(0, NCELL - 1));
            else if (sel == 8) idx = NCELL;
            else idx = NCELL + 1 + int'($urandom_range(0, 16000));
            addr = 16'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7) data = 32'($urandom_range(0, 14));
                else if (sel < 9) data = 32'($urandom_range(15, 20));
                else data = $urandom;
                lead = int'($urandom_range(0, 6)) - 3;
                do_write(addr, data, lead, int'($urandom_range(0, 3)), resp, str, hs, bv);
                model_write(addr, data, mresp, mstr);
                check($sformatf("rnd%0d_bresp", i), resp, mresp);
                check($sformatf("rnd%0d_strobes", i), str, mstr);
                check($sformatf("rnd%0d_ctrl", i), ising_rstn, m_ctrl);
            end else begin
                do_read(addr, int'($urandom_range(0, 3)), rd, resp, arc, rv);
                model_read(addr, md, mresp);
                check($sformatf("rnd%0d_rdata", i), rd, md);
                check($sformatf("rnd%0d_rresp", i), resp, mresp);
            end
        end

        // Final sweep of every cell.
        for (int k = 0; k < NCELL; k++) begin
            do_read(16'(k * 4), 0, rd, resp, arc, rv);
            model_read(16'(k * 4), md, mresp);
            check($sformatf("sweep%0d", k), {resp, rd}, {mresp, md});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
